// File: rtl/hamnhan_axi_master_if.sv
// AXI4-Lite bus between the hamnhan master sequencer and the multiplier slave.
// Signal names follow the AXI master-side naming used on the slave's ports.
interface hamnhan_axi_master_if;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/hamnhan_axi_master.sv
// AXI4-Lite master sequencer for the hamnhan multiplier slave.
// One command = write {a,b} to the slave register, read the product back,
// then present it (with an error flag) on the response port.
module hamnhan_axi_master #(
  parameter logic [31:0] C_BASEADDR = 32'h79C0_0000,
  parameter int          C_OP_WIDTH = 16
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [C_OP_WIDTH-1:0] cmd_a,
  input  logic [C_OP_WIDTH-1:0] cmd_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic [15:0]           txn_count,
  hamnhan_axi_master_if.master  m_axi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WRESP,
    ST_RD,
    ST_RDATA,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_t      r_state;
  logic        r_awvalid;
  logic        r_wvalid;
  logic [31:0] r_wdata;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic [15:0] r_txn_count;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;

  // Address/write-channel handshakes and "this half of the write is finished" flags.
  assign w_aw_hs   = r_awvalid & m_axi.M_AXI_AWREADY;
  assign w_w_hs    = r_wvalid & m_axi.M_AXI_WREADY;
  assign w_aw_done = w_aw_hs | ~r_awvalid;
  assign w_w_done  = w_w_hs | ~r_wvalid;

  // Only one register on the slave, and all writes are full-word.
  assign m_axi.M_AXI_AWADDR  = C_BASEADDR;
  assign m_axi.M_AXI_ARADDR  = C_BASEADDR;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;

  // cmd_ready is a pure state decode so a command is taken in the very cycle IDLE is entered.
  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign txn_count = r_txn_count;

  // Sequencer FSM: write operands, collect BRESP, read product, hold response until taken.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state     <= ST_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_txn_count <= '0;
    end else begin
      // NOTE: every state update here is non-blocking so each branch reads the
      // pre-edge values of all registers, exactly like the flops it describes.
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_wdata   <= {cmd_a, cmd_b};
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= ST_WR;
          end
        end

        ST_WR: begin
          // AW and W retire independently; move on once both are gone.
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WRESP;
          end
        end

        ST_WRESP: begin
          if (m_axi.M_AXI_BVALID) begin
            r_bready <= 1'b0;
            if (m_axi.M_AXI_BRESP == RESP_OKAY) begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD;
            end else begin
              // A failed write makes the product meaningless, so the read is skipped.
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end

        ST_RD: begin
          if (m_axi.M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end
        end

        ST_RDATA: begin
          if (m_axi.M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_data  <= m_axi.M_AXI_RDATA;
            r_rsp_err   <= (m_axi.M_AXI_RRESP != RESP_OKAY);
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_txn_count <= r_txn_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
